// File: rtl/i2s_frame_serializer.sv
// Mono I2S frame serializer and frame-rate pacer: a free-running (bit, div) timebase
// whose registered decodes drive bclk, lrclk, sdata and the once-per-frame new_frame pulse.
// Optional sticky underrun detection is compiled in with `define I2S_UNDERRUN_DETECT_EN.
module i2s_frame_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SLOT_BITS    = 32,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_strobe,
  input  logic                    mute,
  output logic                    new_frame,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_FIRST = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(SAMPLE_WIDTH);

  logic [DIV_W-1:0]        div_cnt;
  logic [DIV_W-1:0]        div_next;
  logic [BIT_W-1:0]        bit_cnt;
  logic [BIT_W-1:0]        bit_next;
  logic                    div_wrap;
  logic [SAMPLE_WIDTH-1:0] word;

  // Timebase next-state: div wraps every bit period, bit wraps every frame.
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    div_next = div_wrap ? '0 : div_cnt + DIV_W'(1);
    bit_next = bit_cnt;
    if (div_wrap) begin
      bit_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  logic [BIT_W-1:0]        slot_pos;
  logic [SAMPLE_WIDTH-1:0] word_shifted;
  logic                    capture;
  logic                    in_data;
  logic                    bclk_d;
  logic                    lrclk_d;
  logic                    sdata_d;
  logic                    new_frame_d;

  // Output decode of the current counter state; registered below so every
  // output lags the state it decodes by exactly one clk.
  always_comb begin
    lrclk_d      = (bit_cnt >= SLOT_FIRST);
    bclk_d       = (div_cnt >= DIV_HALF);
    capture      = (bit_cnt == '0) && (div_cnt == '0);
    new_frame_d  = (bit_cnt == BIT_LAST) && (div_cnt == '0);
    slot_pos     = lrclk_d ? (bit_cnt - SLOT_FIRST) : bit_cnt;
    // One-bit I2S delay: slot position 1 carries the MSB.
    in_data      = (slot_pos != '0) && (slot_pos <= DATA_LAST);
    word_shifted = word << (slot_pos - BIT_W'(1));
    sdata_d      = in_data && word_shifted[SAMPLE_WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      word      <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      new_frame <= 1'b0;
    end else begin
      div_cnt   <= div_next;
      bit_cnt   <= bit_next;
      bclk      <= bclk_d;
      lrclk     <= lrclk_d;
      sdata     <= sdata_d;
      new_frame <= new_frame_d;
      // The word is frozen for the whole frame; mute only matters here.
      if (capture) begin
        word <= mute ? '0 : sample_in;
      end
    end
  end

`ifdef I2S_UNDERRUN_DETECT_EN
  // sample_strobe is a bare advisory pulse (no backpressure); seen records
  // whether one arrived since the last new_frame.
  logic seen;
  logic armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen     <= 1'b0;
      armed    <= 1'b0;
      underrun <= 1'b0;
    end else if (new_frame) begin
      // A strobe coinciding with new_frame belongs to the following frame.
      seen  <= sample_strobe;
      armed <= 1'b1;
      if (armed && !seen) begin
        underrun <= 1'b1;
      end
    end else if (sample_strobe) begin
      seen <= 1'b1;
    end
  end
`else
  logic unused_strobe;
  assign unused_strobe = sample_strobe;
  assign underrun      = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Directed bench for i2s_frame_serializer: table of per-frame vectors checked
// against an expected-frame queue, plus a hand-written mid-frame reset sequence.
module tb_i2s_frame_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_strobe;
  logic        mute;
  logic        new_frame;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  i2s_frame_serializer #(
    .CLKS_PER_BIT (4),
    .SLOT_BITS    (32),
    .SAMPLE_WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_strobe (sample_strobe),
    .mute          (mute),
    .new_frame     (new_frame),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .underrun      (underrun)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] sample;
    logic        mute;
    logic        strobe;
    logic        chg_en;
    logic [15:0] chg_val;
    logic [15:0] exp_word;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_under = 1'b0;
  int          frame_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_new_frame"}, 64'(new_frame), 64'd0);
    check({tag, "_bclk"},      64'(bclk),      64'd0);
    check({tag, "_lrclk"},     64'(lrclk),     64'd0);
    check({tag, "_sdata"},     64'(sdata),     64'd0);
    check({tag, "_underrun"},  64'(underrun),  64'd0);
  endtask

  // Called just before the capture edge of a frame; steps exactly one frame
  // (256 clks) and checks every output shape over it.
  task automatic run_frame(input vec_t v);
    logic [63:0] got;
    int bclk_err = 0;
    int lr_err   = 0;
    int stab_err = 0;
    int nf_cnt   = 0;
    int nf_k     = 0;
    int b;
    int d;
    sample_in = v.sample;
    mute      = v.mute;
    exp_q.push_back({1'b0, v.exp_word, 15'b0, 1'b0, v.exp_word, 15'b0});
    got = '0;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      #1;
      b = (k - 1) / 4;
      d = (k - 1) % 4;
      if (bclk !== (d >= 2)) bclk_err++;
      if (lrclk !== (b >= 32)) lr_err++;
      if (new_frame === 1'b1) begin
        nf_cnt++;
        nf_k = k;
      end
      if (d == 0) got[63-b] = sdata;
      else if (sdata !== got[63-b]) stab_err++;
      sample_strobe = (k == 10) && v.strobe;
      if (k == 81 && v.chg_en) sample_in = v.chg_val;
    end
    check("sdata_frame",       got, exp_q.pop_front());
    check("bclk_shape_errs",   64'(bclk_err), 64'd0);
    check("lrclk_shape_errs",  64'(lr_err),   64'd0);
    check("sdata_stable_errs", 64'(stab_err), 64'd0);
    check("new_frame_count",   64'(nf_cnt),   64'd1);
    check("new_frame_cycle",   64'(nf_k),     64'd253);
`ifdef I2S_UNDERRUN_DETECT_EN
    if (frame_idx >= 1 && !v.strobe) exp_under = 1'b1;
`endif
    check("underrun", 64'(underrun), 64'(exp_under));
    frame_idx++;
  endtask

  initial begin
    reset         = 1'b0;
    sample_in     = '0;
    sample_strobe = 1'b0;
    mute          = 1'b0;

    //                sample    mute  strb  chg   chg_val   exp_word
    vecs[0] = '{16'hA5C3, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hA5C3};
    vecs[1] = '{16'h1234, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h1234};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'h7FFF, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{16'h7FFF, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7FFF};
    vecs[5] = '{16'h8001, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h8001};
    vecs[6] = '{16'h0F0F, 1'b0, 1'b1, 1'b1, 16'hF0F0, 16'h0F0F};
    vecs[7] = '{16'h5A5A, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5A5A};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Mid-frame reset at bit 40 with a word whose bit 8 is set, so sdata and
    // lrclk are both high just before reset hits.
    sample_in = 16'hC3FF;
    mute      = 1'b0;
    for (int k = 1; k <= 161; k++) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_lrclk", 64'(lrclk), 64'd1);
    check("pre_reset_sdata", 64'(sdata), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_under = 1'b0;
    frame_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_frame(vecs[7]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_frame_serializer.md
Name: i2s_frame_serializer

Overview:
- Codec-side partner of the music player output path. Generates the 48 kHz-class `new_frame` pulse that paces the sample chain.
- Accepts the conditioned 16-bit sample and serializes it as mono I2S, carrying the same word in both channels, to a DAC.
- Drives bit clock, LR clock and serial data, and takes the place of the codec's frame/serial logic for simulation or an external DAC.

Parameters:
- CLKS_PER_BIT, 4, system clocks per bit-clock period; even, >=4.
- SLOT_BITS, 32, bit periods per channel slot; frame = 2*SLOT_BITS bits; >=17.
- SAMPLE_WIDTH, 16, sample width; <= SLOT_BITS-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- sample_in  input  SAMPLE_WIDTH  signed sample (valid_sample from conditioner)
- sample_strobe  input  1  one-cycle pulse, new sample produced upstream (new_sample_generated)
- mute  input  1  1 = serialize zeros
- new_frame  output  1  one-cycle pulse, once per frame
- bclk  output  1  I2S bit clock
- lrclk  output  1  I2S word select; 0 = left, 1 = right
- sdata  output  1  I2S serial data, MSB first
- underrun  output  1  sticky flag (see Optional Feature; tied 0 when compiled out)

Behaviour:
- Counters:
  - div: 0..CLKS_PER_BIT-1, wraps.
  - bit: 0..2*SLOT_BITS-1; increments when div wraps, and wraps to 0 after the last bit.
  - Both counters are 0 in the first cycle after reset deasserts.
- Registered outputs: every output is a registered decode of (bit, div), so it appears one clk after the counter state it decodes.
- Reset (async, reset==0): bclk=0, lrclk=0, sdata=0, new_frame=0, underrun=0, shift word=0, counters=0.
- bclk: 0 while div < CLKS_PER_BIT/2, 1 otherwise. Data changes on the bclk falling edge (div==0) and is stable at the rising edge.
- lrclk: 0 for bit < SLOT_BITS, 1 otherwise. It changes at div==0 of bit 0 and bit SLOT_BITS.
- Capture: at (bit=0, div=0), sample_in is latched into the frame word unless mute=1, in which case 0 is latched. The word is held for the entire frame, both slots. mute is sampled only at capture.
- sdata, with I2S one-bit delay:
  - bit b in 1..SAMPLE_WIDTH carries word[SAMPLE_WIDTH-b].
  - bit b in SLOT_BITS+1..SLOT_BITS+SAMPLE_WIDTH carries word[SLOT_BITS+SAMPLE_WIDTH-b].
  - All other bits carry 0.
- new_frame: asserted for exactly one clk after counter state (bit=2*SLOT_BITS-1, div=0). This leaves CLKS_PER_BIT-1 clks for the upstream sample to settle before capture.
- First new_frame after reset release: clk cycle (2*SLOT_BITS-1)*CLKS_PER_BIT+1.
- Period: exactly 2*SLOT_BITS*CLKS_PER_BIT clks. There is no jitter and no dependence on inputs.
- sample_in changing mid-frame has no effect on the current frame.
- Reset asserted mid-frame:
  - All outputs go to reset values immediately.
  - The partial frame is discarded.
  - Timing restarts from bit 0 on release.

Optional Feature:
- Macro: I2S_UNDERRUN_DETECT_EN.
- With the macro defined:
  - An internal flag `seen` is set by sample_strobe and cleared on each new_frame pulse.
  - If new_frame fires while `seen`==0 (no strobe since the previous new_frame), underrun is set and stays at 1 until reset.
  - The first new_frame after reset is exempt.
  - A strobe in the same cycle as new_frame counts toward the next frame.
- Without the macro: underrun is constant 0 and no detection logic is generated.

Test Plan:
- Reset release, CLKS_PER_BIT=4, SLOT_BITS=32 -> first new_frame at cycle 253, then every 256 clks; bclk period 4, duty 50%; lrclk period 256.
- sample_in=16'hA5C3 held across capture -> left bits 1..16 = 1010010111000011, right bits 33..48 identical, all other bits 0; sdata stable at every bclk rise.
- sample_in changes 16'h1234 -> 16'hFFFF at bit 20 -> current frame still shows 16'h1234 in both slots; next frame shows 16'hFFFF.
- mute=1 at capture with sample_in=16'h7FFF -> sdata 0 for the whole frame; mute=0 next capture -> 16'h7FFF emitted.
- reset pulsed low at bit 40 -> all outputs 0 within the same cycle; after release the next new_frame arrives 253 clks later.
- With I2S_UNDERRUN_DETECT_EN: strobe once per frame for 3 frames -> underrun=0; omit strobe for one frame -> underrun=1 after that new_frame and stays 1. Without the macro -> underrun=0 throughout.
